sos_buzzer_module: RTL and testbench
====================================

Name: sos_buzzer_module

Overview:
- Function stage directly downstream of the 3 s SOS control timer.
- On each accepted single-cycle SOS_En pulse, drives the buzzer through one Morse "SOS" pattern: 3 short tones, 3 long tones, 3 short tones, with a fixed gap after every tone.
- Nominal pattern length: 100 ms*6 + 300 ms*3 + 50 ms*9 = 1950 ms, which fits inside the 3 s enable period.

Parameters:
- T1MS, 50_000, CLK cycles per millisecond (50 MHz clock).
- SHORT_MS, 100, short-tone length in ms.
- LONG_MS, 300, long-tone length in ms.
- GAP_MS, 50, silent gap after each tone, in ms.
- TONE_HALF, 12_500, half-period in CLK cycles of the square wave used when SOS_TONE_EN is set (2 kHz at 50 MHz).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- SOS_En  input  1  start request, single-cycle pulse from the control timer.
- Pin_Out  output  1  buzzer drive, active-low (0 = sounding).
- Busy  output  1  high while a pattern is in progress.
- Done  output  1  single-cycle pulse when a pattern completes.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: Pin_Out=1, Busy=0, Done=0, state=IDLE, all counters 0. RST asserted mid-pattern aborts it on the next edge with no Done pulse.
- States: IDLE, TONE, GAP, DONE. Symbol index sym runs 0..8 (4 bits).
- IDLE:
  - SOS_En=1 sampled at edge k gives state=TONE, sym=0 and Busy=1 from edge k.
  - Pin_Out=0 is registered at edge k, so it is visible in the cycle after k (latency 1).
  - SOS_En=0 leaves the state unchanged.
- Tone length: sym 0-2 and 6-8 use SHORT_MS; sym 3-5 use LONG_MS.
- TONE: lasts exactly len*T1MS cycles with Pin_Out=0, then goes to GAP.
- GAP: lasts exactly GAP_MS*T1MS cycles with Pin_Out=1.
  - If sym<8: sym increments and state goes to TONE.
  - If sym=8: state goes to DONE.
- DONE: lasts 1 cycle with Done=1, Busy=0, Pin_Out=1, then goes to IDLE.
- Timing: Busy is high for exactly 1950*T1MS cycles at the default parameters.
- Counters:
  - ms prescaler counts 0..T1MS-1 (16 bits). It is cleared whenever the state changes, so phase lengths are exact multiples of T1MS.
  - ms counter is 9 bits and compares against the phase length minus 1. It wraps to 0 on each phase change.
- SOS_En while Busy=1 or in DONE: ignored, not queued. No restart and no extension of the pattern.
- Simultaneous RST and SOS_En: reset wins.

Optional Feature:
- Macro: SOS_TONE_EN.
- Defined (passive buzzer):
  - During TONE, Pin_Out toggles every TONE_HALF cycles, starting at 0 on entry to TONE.
  - The toggle counter is cleared on every phase change.
  - Pin_Out is forced to 1 outside TONE.
- Undefined (active buzzer): Pin_Out is a steady 0 for the whole of TONE. No toggle counter is synthesised.

Decomposition:
- Shared package sos_pkg:
  - state encoding (IDLE=0, TONE=1, GAP=2, DONE=3);
  - SYM_COUNT=9;
  - a function returning the tone length for a given sym.
- Sub-module ms_tick_gen:
  - parameter T1MS;
  - inputs CLK, RST, clr;
  - output tick, a 1-cycle pulse every T1MS cycles since the last clr.

Test Plan:
- Bench parameters for all scenarios: T1MS=10, SHORT_MS=2, LONG_MS=6, GAP_MS=1.
- Reset: RST=1 for 3 cycles -> Pin_Out=1, Busy=0, Done=0.
- Single pulse:
  - Stimulus: SOS_En pulse at cycle 0.
  - Pin_Out low runs: 20,20,20,60,60,60,20,20,20 cycles.
  - Pin_Out high gaps: 10 cycles after each run.
  - Busy high for 390 cycles; Done pulses at cycle 390; state returns to IDLE.
- Ignored request: SOS_En re-pulsed at cycle 100 and at cycle 390 (during DONE) -> waveform identical to the single-pulse case; no second pattern.
- Mid-pattern reset:
  - Stimulus: RST at cycle 150, then SOS_En at cycle 160.
  - Response: Pin_Out=1 and Busy=0 from cycle 151, no Done pulse; a fresh full pattern starts from sym 0.
- Back-to-back: SOS_En at cycle 0 and cycle 395 -> two complete patterns and two Done pulses, at cycles 390 and 785.
- SOS_TONE_EN with TONE_HALF=2 -> each 20-cycle short tone shows 5 low/high pairs of 2 cycles each; Pin_Out=1 throughout every GAP.

Source files
------------

// File: rtl/sos_pkg.sv
// Shared definitions for the SOS buzzer: phase encoding, pattern length and
// the per-symbol tone length lookup.
package sos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned SYM_COUNT = 9;

  // Symbols 3..5 are the dashes of S-O-S; everything else is a dot.
  function automatic logic [8:0] tone_len_ms(input logic [3:0] sym,
                                             input logic [8:0] short_ms,
                                             input logic [8:0] long_ms);
    return (sym >= 4'd3 && sym <= 4'd5) ? long_ms : short_ms;
  endfunction

endpackage

// File: rtl/sos_buzzer_module_ms_tick_gen.sv
// Millisecond prescaler: single-cycle tick every T1MS cycles, restarted by clr.
module ms_tick_gen #(
  parameter int unsigned T1MS = 50_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(T1MS - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST || clr)        cnt_q <= 16'd0;
    else if (cnt_q == LAST) cnt_q <= 16'd0;
    else                   cnt_q <= cnt_q + 16'd1;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sos_buzzer_module.sv
// Plays one Morse SOS on the active-low buzzer pin per accepted SOS_En pulse.
// Define SOS_TONE_EN to drive a passive buzzer with a square wave during tones.
module sos_buzzer_module
  import sos_pkg::*;
#(
  parameter int unsigned T1MS      = 50_000,
  parameter int unsigned SHORT_MS  = 100,
  parameter int unsigned LONG_MS   = 300,
  parameter int unsigned GAP_MS    = 50,
  parameter int unsigned TONE_HALF = 12_500
) (
  input  logic CLK,
  input  logic RST,
  input  logic SOS_En,
  output logic Pin_Out,
  output logic Busy,
  output logic Done
);

  if (T1MS < 1 || T1MS > 65536 || TONE_HALF < 1 || TONE_HALF > 65536) begin : g_bad_param
    $error("sos_buzzer_module: T1MS/TONE_HALF out of 16-bit counter range");
  end

  state_e      state_q, state_d;
  logic [3:0]  sym_q, sym_d;
  logic [8:0]  ms_q, ms_d;
  logic        pin_q, pin_d;
  logic        tick, phase_chg, phase_end;
  logic [8:0]  phase_last_ms;

  assign phase_chg = (state_d != state_q);

  ms_tick_gen #(.T1MS(T1MS)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (phase_chg),
    .tick (tick)
  );

  assign phase_last_ms = (state_q == TONE)
                       ? tone_len_ms(sym_q, 9'(SHORT_MS), 9'(LONG_MS)) - 9'd1
                       : 9'(GAP_MS - 1);
  assign phase_end = tick && (ms_q == phase_last_ms);

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    case (state_q)
      IDLE: if (SOS_En) begin
        state_d = TONE;
        sym_d   = 4'd0;
      end
      TONE: if (phase_end) state_d = GAP;
      GAP: if (phase_end) begin
        if (sym_q < 4'(SYM_COUNT - 1)) begin
          sym_d   = sym_q + 4'd1;
          state_d = TONE;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ms_d = ms_q;
    if (phase_chg || state_q == IDLE) ms_d = 9'd0;
    else if (tick)                    ms_d = ms_q + 9'd1;
  end

`ifdef SOS_TONE_EN
  localparam logic [15:0] TOG_LAST = 16'(TONE_HALF - 1);

  logic [15:0] tog_q, tog_d;

  always_comb begin
    tog_d = tog_q + 16'd1;
    if (phase_chg || tog_q == TOG_LAST) tog_d = 16'd0;
    // Square wave always starts low on tone entry.
    pin_d = 1'b1;
    if (state_d == TONE) begin
      if (state_q != TONE)         pin_d = 1'b0;
      else if (tog_q == TOG_LAST)  pin_d = ~pin_q;
      else                         pin_d = pin_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) tog_q <= 16'd0;
    else     tog_q <= tog_d;
  end
`else
  always_comb begin
    pin_d = (state_d != TONE);
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sym_q   <= 4'd0;
      ms_q    <= 9'd0;
      pin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      ms_q    <= ms_d;
      pin_q   <= pin_d;
    end
  end

  assign Pin_Out = pin_q;
  assign Busy    = (state_q == TONE) || (state_q == GAP);
  assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_sos_buzzer_module.sv
// Self-checking bench for sos_buzzer_module; expected waveform is derived from
// the pattern offset since the accepted start pulse.
module tb_sos_buzzer_module;

  localparam int T1MS  = 10;
  localparam int SHORT = 2;
  localparam int LONG  = 6;
  localparam int GAPMS = 1;
  localparam int HALF  = 2;
  localparam int TOTAL = (SHORT * 6 + LONG * 3 + GAPMS * 9) * T1MS;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic SOS_En = 1'b0;
  logic Pin_Out, Busy, Done;

  int checks = 0;
  int failures = 0;
  int m_off = -1;

  sos_buzzer_module #(
    .T1MS(T1MS), .SHORT_MS(SHORT), .LONG_MS(LONG), .GAP_MS(GAPMS), .TONE_HALF(HALF)
  ) dut (
    .CLK(CLK), .RST(RST), .SOS_En(SOS_En),
    .Pin_Out(Pin_Out), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  // {Pin_Out, Busy, Done} expected at pattern offset off (-1 = idle).
  function automatic logic [2:0] model_out(input int off);
    int o;
    int len;
    logic pin;
    if (off < 0) return 3'b100;
    if (off == TOTAL) return 3'b101;
    o = off;
    for (int s = 0; s < 9; s++) begin
      len = ((s >= 3 && s <= 5) ? LONG : SHORT) * T1MS;
      if (o < len) begin
`ifdef SOS_TONE_EN
        pin = ((o / HALF) % 2) != 0;
`else
        pin = 1'b0;
`endif
        return {pin, 2'b10};
      end
      o -= len;
      if (o < GAPMS * T1MS) return 3'b110;
      o -= GAPMS * T1MS;
    end
    return 3'b100;
  endfunction

  task automatic step(input logic en, input logic rst);
    SOS_En = en;
    RST    = rst;
    @(posedge CLK);
    if (rst)            m_off = -1;
    else if (m_off < 0) begin
      if (en) m_off = 0;
    end else begin
      m_off++;
      if (m_off > TOTAL) m_off = -1;
    end
    #1;
    SOS_En = 1'b0;
    RST    = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if ({Pin_Out, Busy, Done} !== 3'b100) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b want=100", i, {Pin_Out, Busy, Done});
      end
    end
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    int low_cnt = 0;
    int done_at = -1;
    step(1'b0, 1'b1);
    for (int i = 0; i <= 400; i++) begin
      step(i == 0, 1'b0);
      if (Busy === 1'b1) busy_cnt++;
      if (Pin_Out === 1'b0) low_cnt++;
      if (Done === 1'b1) done_at = i;
      checks++;
      if ({Pin_Out, Busy, Done} !== model_out(m_off)) begin
        failures++;
        if (failures < 20)
          $display("FAIL single cyc=%0d got=%b want=%b", i, {Pin_Out, Busy, Done}, model_out(m_off));
      end
    end
    checks++;
    if (busy_cnt != 390) begin
      failures++;
      $display("FAIL single_busy_len got=%0d want=390", busy_cnt);
    end
    checks++;
    if (done_at != 390) begin
      failures++;
      $display("FAIL single_done_cycle got=%0d want=390", done_at);
    end
`ifndef SOS_TONE_EN
    checks++;
    if (low_cnt != 300) begin
      failures++;
      $display("FAIL single_low_total got=%0d want=300", low_cnt);
    end
`endif
  endtask

  task automatic test_ignored();
    int dones = 0;
    step(1'b0, 1'b1);
    for (int i = 0; i <= 400; i++) begin
      step(i == 0 || i == 100 || i == 390, 1'b0);
      if (Done === 1'b1) dones++;
      checks++;
      if ({Pin_Out, Busy, Done} !== model_out(m_off)) begin
        failures++;
        if (failures < 20)
          $display("FAIL ignored cyc=%0d got=%b want=%b", i, {Pin_Out, Busy, Done}, model_out(m_off));
      end
    end
    checks++;
    if (dones != 1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_no_restart dones=%0d busy=%b want dones=1 busy=0", dones, Busy);
    end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    int done_at = -1;
    step(1'b0, 1'b1);
    for (int i = 0; i <= 560; i++) begin
      step(i == 0 || i == 160, i == 151);
      if (Done === 1'b1) begin
        dones++;
        done_at = i;
      end
      checks++;
      if ({Pin_Out, Busy, Done} !== model_out(m_off)) begin
        failures++;
        if (failures < 20)
          $display("FAIL mid_reset cyc=%0d got=%b want=%b", i, {Pin_Out, Busy, Done}, model_out(m_off));
      end
    end
    checks++;
    if (dones != 1 || done_at != 550) begin
      failures++;
      $display("FAIL mid_reset_done dones=%0d at=%0d want 1 at 550", dones, done_at);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int first = -1;
    int last = -1;
    step(1'b0, 1'b1);
    for (int i = 0; i <= 800; i++) begin
      step(i == 0 || i == 395, 1'b0);
      if (Done === 1'b1) begin
        dones++;
        if (first < 0) first = i;
        last = i;
      end
      checks++;
      if ({Pin_Out, Busy, Done} !== model_out(m_off)) begin
        failures++;
        if (failures < 20)
          $display("FAIL back_to_back cyc=%0d got=%b want=%b", i, {Pin_Out, Busy, Done}, model_out(m_off));
      end
    end
    checks++;
    if (dones != 2 || first != 390 || last != 785) begin
      failures++;
      $display("FAIL back_to_back_done n=%0d first=%0d last=%0d want 2,390,785", dones, first, last);
    end
  endtask

  task automatic test_random();
    logic en;
    logic rst;
    step(1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(en, rst);
      checks++;
      if ({Pin_Out, Busy, Done} !== model_out(m_off)) begin
        failures++;
        if (failures < 20)
          $display("FAIL random cyc=%0d got=%b want=%b", i, {Pin_Out, Busy, Done}, model_out(m_off));
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
